fifo_axis_reader: RTL and testbench

- Drains a sync FIFO (push/pop, 1-cycle registered dout, dout forced to 0 when not popping) and presents its contents as an AXI4-Stream master.
- Sits between a CGRA lane's output FIFO and the downstream AXIS consumer (packetiser/MAC side).
- Hides the FIFO's 1-cycle pop latency with a 2-entry skid buffer, sustaining 1 beat/cycle under continuous tready.
- Generates tlast on fixed-length packets.

---
 rtl/fifo_axis_reader.sv | 160 ++++++++++++++++
 tb/tb_fifo_axis_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
// Drains a registered-output sync FIFO into an AXI4-Stream master through a 2-entry skid buffer.
// Optional hs/stall statistics ports are enabled by defining FIFO_AXIS_READER_STATS_EN.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef FIFO_AXIS_READER_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_stall
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_pop_d1;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_last0;
    logic                  r_last1;
    logic [CNT_WIDTH-1:0]  r_cap_cnt;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;

    logic                  w_hs;
    logic                  w_cap_last;
    logic                  w_load0;
    logic                  w_load1;
    logic                  w_shift;
    logic [2:0]            w_occ;

    assign w_hs       = r_tvalid && m_axis_tready;
    assign w_cap_last = (r_cap_cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            S_EMPTY: if (r_pop_d1) w_state_next = S_ONE;
            S_ONE: begin
                if (r_pop_d1 && !w_hs)      w_state_next = S_TWO;
                else if (!r_pop_d1 && w_hs) w_state_next = S_EMPTY;
            end
            S_TWO:   if (w_hs && !r_pop_d1) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Occupancy counts buffered words plus the word still inside the FIFO's read register.
    always_comb begin
        w_load0  = 1'b0;
        w_load1  = 1'b0;
        w_shift  = 1'b0;
        w_occ    = 3'(r_state) + {2'b00, r_pop_d1};
        fifo_pop = rst_n && enable && !fifo_empty && (w_occ < (3'd2 + {2'b00, w_hs}));
        unique case (r_state)
            S_EMPTY: w_load0 = r_pop_d1;
            S_ONE: begin
                w_load0 = r_pop_d1 && w_hs;
                w_load1 = r_pop_d1 && !w_hs;
            end
            S_TWO: begin
                w_shift = w_hs;
                w_load1 = r_pop_d1 && w_hs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid entries are reset (unlike a plain RAM) because tdata/tlast must read 0 out of reset.
            r_data0    <= '0;
            r_data1    <= '0;
            r_last0    <= 1'b0;
            r_last1    <= 1'b0;
            r_pop_d1   <= 1'b0;
            r_tvalid   <= 1'b0;
            r_cap_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_pop_d1 <= fifo_pop && !fifo_empty;
            r_tvalid <= (w_state_next != S_EMPTY);
            if (w_shift) begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
            end else if (w_load0) begin
                r_data0 <= fifo_dout;
                r_last0 <= w_cap_last;
            end
            if (w_load1) begin
                r_data1 <= fifo_dout;
                r_last1 <= w_cap_last;
            end
            if (r_pop_d1) begin
                r_cap_cnt <= w_cap_last ? '0 : r_cap_cnt + 1'b1;
            end
            if (w_hs) begin
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    assign m_axis_tdata  = r_data0;
    assign m_axis_tlast  = r_last0;
    assign m_axis_tvalid = r_tvalid;

    // Delivery order equals capture order, so the output-side beat count must agree with the stored tlast.
    a_tlast_matches_beat: assert property (@(posedge clk) disable iff (!rst_n)
        w_hs |-> ((r_beat_cnt == LAST_BEAT) == m_axis_tlast));

`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_beats <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_hs) r_stat_beats <= r_stat_beats + 32'd1;
            if (r_tvalid && !m_axis_tready && (r_stat_stall != 32'hFFFF_FFFF)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed and randomized bench for fifo_axis_reader (PKT_LEN=4) with a queue-based FIFO and stream model.
module tb_fifo_axis_reader;

    localparam int DW = 32;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty = 1'b1;
    logic          fifo_pop;
    logic [DW-1:0] fifo_dout = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0]   stat_beats;
    logic [31:0]   stat_stall;
`endif

    always #5 clk = ~clk;

    fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .fifo_dout     (fifo_dout),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
`ifdef FIFO_AXIS_READER_STATS_EN
        ,
        .stat_beats    (stat_beats),
        .stat_stall    (stat_stall)
`endif
    );

    // Sync FIFO model: registered dout, zero when not popping, empty flag updated at the edge.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] fifo_word;
    int unsigned   pop_cnt = 0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;

    always @(posedge clk) begin
        if (fifo_pop && !fifo_empty) begin
            fifo_word = fq.pop_front();
            pop_cnt   = pop_cnt + 1;
            fifo_dout <= fifo_word;
        end else begin
            fifo_dout <= '0;
        end
        if (push_en) fq.push_back(push_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Stream reference: words leave in push order, tlast on every PL-th beat since reset.
    logic [DW-1:0] sb[$];
    int            idx = 0;
    int unsigned   del_cnt = 0;
    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int unsigned   hs_model = 0;
    int unsigned   stall_model = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called with inputs already set just after a negedge; checks this cycle, then waits for the next negedge.
    task automatic tick();
        logic          hs_now;
        logic [DW-1:0] exp_w;
        int            occ;
        #1;
        hs_now = tvalid && tready;
        if (prev_stall) begin
            check("hold_valid", {31'd0, tvalid}, 1);
            check("hold_data", tdata, prev_data);
            check("hold_last", {31'd0, tlast}, {31'd0, prev_last});
        end
        if (fifo_pop && !fifo_empty) begin
            occ = int'(pop_cnt) - int'(del_cnt);
            check("pop_bound", {31'd0, (occ + 1 - int'(hs_now)) <= 2}, 1);
        end
        if (hs_now) begin
            if (sb.size() == 0) begin
                check("extra_beat", {31'd0, tvalid}, 0);
            end else begin
                exp_w = sb.pop_front();
                check("tdata", tdata, exp_w);
                check("tlast", {31'd0, tlast}, {31'd0, (idx % PL) == PL - 1});
                idx++;
            end
            del_cnt++;
            hs_model++;
        end
        if (tvalid && !tready) stall_model++;
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        @(negedge clk);
    endtask

    initial begin
        int  base;
        int  seg_start;
        logic saw_gap;

        rst_n  = 1'b1;
        enable = 1'b0;
        tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", {31'd0, tvalid}, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tlast", {31'd0, tlast}, 0);
        check("rst_pop", {31'd0, fifo_pop}, 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Idle with an empty FIFO.
        for (int i = 0; i < 20; i++) begin
            #1;
            check("idle_pop", {31'd0, fifo_pop}, 0);
            check("idle_tvalid", {31'd0, tvalid}, 0);
            check("idle_tdata", tdata, 0);
            check("idle_tlast", {31'd0, tlast}, 0);
            tick();
        end

        // Streaming: preload 0x10..0x17 with pops disabled, then release with tready high.
        enable = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_en   = 1'b1;
            push_data = 32'h10 + 32'(i);
            sb.push_back(push_data);
            #1 check("preload_nopop", {31'd0, fifo_pop}, 0);
            tick();
        end
        push_en = 1'b0;
        enable  = 1'b1;
        #1;
        check("lat_pop", {31'd0, fifo_pop}, 1);
        check("lat_v0", {31'd0, tvalid}, 0);
        tick();
        #1 check("lat_v1", {31'd0, tvalid}, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1 check("stream_nobubble", {31'd0, tvalid}, 1);
            tick();
        end
        check("stream_drained", 32'(sb.size()), 0);

        // Backpressure: tready pattern 1,0,0 repeating.
        for (int k = 0; k < 60; k++) begin
            tready    = (k % 3 == 0);
            push_en   = (k < 8);
            push_data = 32'h10 + 32'(k);
            if (push_en) sb.push_back(push_data);
            tick();
        end
        push_en = 1'b0;
        check("bp_drained", 32'(sb.size()), 0);

        // FIFO runs dry after 3 words; 2 more arrive 5 cycles later.
        tready    = 1'b1;
        seg_start = idx;
        saw_gap   = 1'b0;
        for (int k = 0; k < 25; k++) begin
            push_en   = (k < 3) || (k == 8) || (k == 9);
            push_data = 32'h20 + 32'((k < 3) ? k : k - 5);
            if (push_en) sb.push_back(push_data);
            #1;
            if ((idx - seg_start == 3) && !tvalid) saw_gap = 1'b1;
            tick();
        end
        push_en = 1'b0;
        check("midstream_gap", {31'd0, saw_gap}, 1);
        check("midstream_beats", 32'(idx - seg_start), 5);
        check("midstream_drained", 32'(sb.size()), 0);

        // enable dropped with one pop in flight: exactly that word is delivered.
        enable = 1'b0;
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_en   = 1'b1;
            push_data = 32'h30 + 32'(i);
            sb.push_back(push_data);
            tick();
        end
        push_en = 1'b0;
        base    = idx;
        enable  = 1'b1;
        #1 check("en_pop", {31'd0, fifo_pop}, 1);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("en_off_nopop", {31'd0, fifo_pop}, 0);
            tick();
        end
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("en_off_nopop", {31'd0, fifo_pop}, 0);
            tick();
        end
        check("en_inflight_delivered", 32'(idx - base), 1);

        // Async reset mid-packet with two words popped and held.
        tready = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_tvalid", {31'd0, tvalid}, 0);
        check("arst_tdata", tdata, 0);
        check("arst_tlast", {31'd0, tlast}, 0);
        check("arst_pop", {31'd0, fifo_pop}, 0);
        sb          = fq;
        idx         = 0;
        del_cnt     = pop_cnt;
        prev_stall  = 1'b0;
        hs_model    = 0;
        stall_model = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push_en   = (k < 3);
            push_data = 32'h40 + 32'(k);
            if (push_en) sb.push_back(push_data);
            tick();
        end
        push_en = 1'b0;
        check("post_reset_beats", 32'(idx), 4);
        check("post_reset_drained", 32'(sb.size()), 0);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            tready    = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            push_en   = ($urandom_range(0, 1) == 1);
            push_data = $urandom;
            if (push_en) sb.push_back(push_data);
            tick();
        end
        push_en = 1'b0;
        enable  = 1'b1;
        tready  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0 && !tvalid && fifo_empty) break;
            tick();
        end
        check("random_drained", 32'(sb.size()), 0);
        #1 check("random_idle", {31'd0, tvalid}, 0);

`ifdef FIFO_AXIS_READER_STATS_EN
        check("stat_beats", stat_beats, hs_model);
        check("stat_stall", stat_stall, stall_model);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
